hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Hazard detection and forwarding block for the 5-stage MIPS pipeline.
- Consumes per-stage control bits from the pipeline controller (regwrite/memtoreg per stage, branchD) and datapath register indices.
- Produces stallF/stallD/stallE, flushE/flushM and forwarding selects; flushE drives the controller's D->E control register clear.
- Contains a sequential divide-handshake FSM that freezes the front of the pipeline while the iterative divider runs, plus a saturating stall-cycle counter.

Parameters:
DIV_MAX_CYCLES, 40, BUSY-state cycle limit before the timeout error is raised
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
rsD, rtD  in  5  source registers in D
rsE, rtE  in  5  source registers in E
writeregE, writeregM, writeregW  in  5  destination register per stage
regwriteE, regwriteM, regwriteW  in  1  register write enable per stage
memtoregE, memtoregM  in  1  load in E / M
branchD  in  1  branch in D (comparison resolved in D)
divE  in  1  div/divu occupying E
div_ready  in  1  divider result valid, one-cycle pulse
div_start  out  1  divider launch pulse
forwardAD, forwardBD  out  1  D-stage compare operand from M ALU result
forwardAE, forwardBE  out  2  E operand: 00 regfile, 01 W result, 10 M ALU result
stallF, stallD, stallE  out  1  hold PC / IF-ID / ID-EX registers
flushE, flushM  out  1  bubble into E / M
div_timeout  out  1  sticky error: divider exceeded DIV_MAX_CYCLES
stall_cycles  out  CNT_W  count of cycles with stallF=1, saturating

Behaviour:
- Combinational outputs follow the current inputs and state.
- While rst=1, all stall/flush/forward outputs and div_start are forced to 0.
- Reset state: FSM=IDLE, busy counter=0, div_timeout=0, stall_cycles=0.
- Register 0 never matches in any comparison.
- forwardAE: 10 if regwriteM and writeregM==rsE; else 01 if regwriteW and writeregW==rsE; else 00. M has priority over W. forwardBE is the same with rtE.
- forwardAD = regwriteM and writeregM==rsD. forwardBD is the same with rtD.
- lwstall = memtoregE and (rtE==rsD or rtE==rtD).
- branchstall = branchD and ((regwriteE and writeregE in {rsD,rtD}) or (memtoregM and writeregM in {rsD,rtD})).
- divstall = 1 in state IDLE with divE=1, and in state BUSY; 0 in DONE.
- stallF = stallD = lwstall | branchstall | divstall.
- stallE = divstall.
- flushE = (lwstall | branchstall) & ~divstall. A divide freezes E, so it is never flushed.
- flushM = divstall: bubbles enter M while the divide is held in E.
- FSM IDLE:
  - divE=1 -> div_start=1 for this cycle only; next state BUSY with busy counter cleared.
  - divE=0 -> stay in IDLE.
- FSM BUSY:
  - Counter increments each cycle.
  - div_ready=1 -> DONE.
  - Counter reaches DIV_MAX_CYCLES-1 with no ready -> set div_timeout, go to DONE.
  - div_ready arriving on the timeout cycle counts as normal completion; div_timeout is not set.
- FSM DONE:
  - No divstall, so the divide leaves E at the end of this cycle.
  - Next state is always IDLE.
  - divE is still high here and must not relaunch the divider.
- div_ready in IDLE or DONE is ignored.
- div_timeout stays set until rst.
- stall_cycles increments on each clk edge where stallF=1 and rst=0, saturating at all-ones.
- Reset asserted mid-divide returns the FSM to IDLE immediately; div_start stays 0 on that cycle.

Decomposition:
- Shared package/header holds the forwarding select constants (FWD_RF=00, FWD_W=01, FWD_M=10) and the FSM state encoding (IDLE, BUSY, DONE). The datapath muxes use the same constants.
- Natural sub-module: div_handshake_fsm. It contains the FSM, busy counter and timeout, and outputs divstall and div_start.
- Forwarding/stall logic and the stall counter stay in hazard_unit.

Test Plan:
- Forwarding priority: rsE=5, regwriteM=1 writeregM=5, regwriteW=1 writeregW=5 -> forwardAE=10. Drop regwriteM -> forwardAE=01. Set rsE=0 with writeregM=0 -> forwardAE=00.
- Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1, stallE=0, stall_cycles increments by 1.
- Branch hazard: branchD=1, regwriteE=1, writeregE=rtD=3 -> stall+flushE. Next case: memtoregM=1, writeregM=rsD=4 -> stall. Next case: regwriteM only (no load), writeregM=rsD -> no stall, forwardAD=1.
- Divide handshake: divE=1, div_ready after 5 BUSY cycles. Expect:
  - div_start=1 for exactly one cycle.
  - stallF/D/E=1 and flushM=1 for 6 cycles (launch + 5 BUSY).
  - DONE cycle: all stalls 0 and no second div_start.
- Timeout: DIV_MAX_CYCLES=4, div_ready never asserted -> div_timeout rises after 4 BUSY cycles and stays 1; FSM passes through DONE to IDLE.
- Reset mid-divide: rst high in BUSY -> next cycle state IDLE, all outputs 0, stall_cycles=0. A later divE relaunches with a fresh div_start.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the MIPS hazard unit: forwarding select codes,
// divide-handshake state encoding and the register-match helper.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwdSel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_t;

  // $zero is hard-wired, so it never participates in a hazard
  function automatic logic regHit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-facing bundle of the hazard unit: stage register indices and
// control bits in, stall/flush/forward selects and divider handshake out.
interface hazard_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       rsD, rtD, rsE, rtE;
  logic [4:0]       writeregE, writeregM, writeregW;
  logic             regwriteE, regwriteM, regwriteW;
  logic             memtoregE, memtoregM;
  logic             branchD;
  logic             divE;
  logic             div_ready;
  logic             div_start;
  logic             forwardAD, forwardBD;
  logic [1:0]       forwardAE, forwardBE;
  logic             stallF, stallD, stallE;
  logic             flushE, flushM;
  logic             div_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, divE, div_ready,
    input  div_start, forwardAD, forwardBD, forwardAE, forwardBE,
           stallF, stallD, stallE, flushE, flushM, div_timeout, stall_cycles
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, divE, div_ready,
    output div_start, forwardAD, forwardBD, forwardAE, forwardBE,
           stallF, stallD, stallE, flushE, flushM, div_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_unit_div_handshake_fsm.sv
// Divide handshake: launches the iterative divider, holds the pipeline front
// while it runs, and flags a sticky timeout if it never answers.
module div_handshake_fsm
  import hazard_unit_pkg::*;
#(
  parameter int unsigned DIV_MAX_CYCLES = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic divE,
  input  logic divReady,
  output logic divStart,
  output logic divStall,
  output logic divTimeout
);

  localparam int unsigned CW = $clog2(DIV_MAX_CYCLES) + 1;

  divState_t       state, stateNext;
  logic [CW-1:0]   busyCnt;
  logic            atLimit;

  assign atLimit = (busyCnt == CW'(DIV_MAX_CYCLES - 1));

  always_comb begin
    stateNext = state;
    divStart  = 1'b0;
    divStall  = 1'b0;
    unique case (state)
      IDLE: if (divE) begin
        divStart  = 1'b1;
        divStall  = 1'b1;
        stateNext = BUSY;
      end
      BUSY: begin
        divStall = 1'b1;
        if (divReady || atLimit) stateNext = DONE;
      end
      // divE is still high here; returning to IDLE without launching lets the divide retire
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busyCnt    <= '0;
      divTimeout <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE) begin
        busyCnt <= '0;
      end else if (state == BUSY) begin
        busyCnt <= busyCnt + CW'(1);
        if (atLimit && !divReady) divTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the 5-stage MIPS pipeline, including the
// divide freeze and a saturating count of front-end stall cycles.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned DIV_MAX_CYCLES = 40,
  parameter int unsigned CNT_W          = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hz
);

  logic             divStall, divStartRaw;
  logic             lwStall, branchStall, stallAny;
  fwdSel_t          fwdAE, fwdBE;
  logic [CNT_W-1:0] stallCycles;

  div_handshake_fsm #(
    .DIV_MAX_CYCLES(DIV_MAX_CYCLES)
  ) uDivFsm (
    .clk        (clk),
    .rst        (rst),
    .divE       (hz.divE),
    .divReady   (hz.div_ready),
    .divStart   (divStartRaw),
    .divStall   (divStall),
    .divTimeout (hz.div_timeout)
  );

  always_comb begin
    fwdAE = FWD_RF;
    if (hz.regwriteM && regHit(hz.rsE, hz.writeregM))      fwdAE = FWD_M;
    else if (hz.regwriteW && regHit(hz.rsE, hz.writeregW)) fwdAE = FWD_W;
    fwdBE = FWD_RF;
    if (hz.regwriteM && regHit(hz.rtE, hz.writeregM))      fwdBE = FWD_M;
    else if (hz.regwriteW && regHit(hz.rtE, hz.writeregW)) fwdBE = FWD_W;
  end

  assign lwStall = hz.memtoregE && (regHit(hz.rsD, hz.rtE) || regHit(hz.rtD, hz.rtE));

  assign branchStall = hz.branchD &&
    ((hz.regwriteE && (regHit(hz.rsD, hz.writeregE) || regHit(hz.rtD, hz.writeregE))) ||
     (hz.memtoregM && (regHit(hz.rsD, hz.writeregM) || regHit(hz.rtD, hz.writeregM))));

  assign stallAny = !rst && (lwStall || branchStall || divStall);

  assign hz.stallF    = stallAny;
  assign hz.stallD    = stallAny;
  assign hz.stallE    = !rst && divStall;
  // a divide holds E in place, so a competing hazard must not bubble it away
  assign hz.flushE    = !rst && (lwStall || branchStall) && !divStall;
  assign hz.flushM    = !rst && divStall;
  assign hz.div_start = !rst && divStartRaw;
  assign hz.forwardAE = rst ? 2'b00 : fwdAE;
  assign hz.forwardBE = rst ? 2'b00 : fwdBE;
  assign hz.forwardAD = !rst && hz.regwriteM && regHit(hz.rsD, hz.writeregM);
  assign hz.forwardBD = !rst && hz.regwriteM && regHit(hz.rtD, hz.writeregM);

  always_ff @(posedge clk) begin
    if (rst)                                  stallCycles <= '0;
    else if (stallAny && stallCycles != '1)   stallCycles <= stallCycles + CNT_W'(1);
  end

  assign hz.stall_cycles = stallCycles;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (default limits, and a short divide
// timeout with a narrow counter) driven identically and checked against a model.
module tb_hazard_unit;

  typedef struct packed {
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, mtrE, mtrM, branchD, divE, divReady;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fAE, fBE;
    logic        fAD, fBD, sF, sD, sE, fE, fM, dStart, tmo;
    logic [31:0] cnt;
  } outs_t;

  logic  clk = 1'b0;
  logic  rst;
  stim_t cur;
  outs_t obsA, obsB;
  int unsigned nChecks = 0;
  int unsigned nPass   = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(32)) hzA ();
  hazard_unit_if #(.CNT_W(4))  hzB ();

  hazard_unit #(.DIV_MAX_CYCLES(40), .CNT_W(32)) dutA (.clk(clk), .rst(rst), .hz(hzA));
  hazard_unit #(.DIV_MAX_CYCLES(4),  .CNT_W(4))  dutB (.clk(clk), .rst(rst), .hz(hzB));

  assign rst = cur.rst;
  assign hzA.rsD = cur.rsD;  assign hzB.rsD = cur.rsD;
  assign hzA.rtD = cur.rtD;  assign hzB.rtD = cur.rtD;
  assign hzA.rsE = cur.rsE;  assign hzB.rsE = cur.rsE;
  assign hzA.rtE = cur.rtE;  assign hzB.rtE = cur.rtE;
  assign hzA.writeregE = cur.wrE;  assign hzB.writeregE = cur.wrE;
  assign hzA.writeregM = cur.wrM;  assign hzB.writeregM = cur.wrM;
  assign hzA.writeregW = cur.wrW;  assign hzB.writeregW = cur.wrW;
  assign hzA.regwriteE = cur.rwE;  assign hzB.regwriteE = cur.rwE;
  assign hzA.regwriteM = cur.rwM;  assign hzB.regwriteM = cur.rwM;
  assign hzA.regwriteW = cur.rwW;  assign hzB.regwriteW = cur.rwW;
  assign hzA.memtoregE = cur.mtrE; assign hzB.memtoregE = cur.mtrE;
  assign hzA.memtoregM = cur.mtrM; assign hzB.memtoregM = cur.mtrM;
  assign hzA.branchD   = cur.branchD;  assign hzB.branchD   = cur.branchD;
  assign hzA.divE      = cur.divE;     assign hzB.divE      = cur.divE;
  assign hzA.div_ready = cur.divReady; assign hzB.div_ready = cur.divReady;

  assign obsA = {hzA.forwardAE, hzA.forwardBE, hzA.forwardAD, hzA.forwardBD,
                 hzA.stallF, hzA.stallD, hzA.stallE, hzA.flushE, hzA.flushM,
                 hzA.div_start, hzA.div_timeout, hzA.stall_cycles};
  assign obsB = {hzB.forwardAE, hzB.forwardBE, hzB.forwardAD, hzB.forwardBD,
                 hzB.stallF, hzB.stallD, hzB.stallE, hzB.flushE, hzB.flushM,
                 hzB.div_start, hzB.div_timeout, 28'd0, hzB.stall_cycles};

  // Reference model: divide progress as "in flight / retiring" plus elapsed busy cycles
  bit          mDividing[2];
  bit          mLeaving[2];
  bit          mTmo[2];
  int unsigned mBusy[2];
  longint unsigned mCnt[2];
  int unsigned     divMax[2] = '{40, 4};
  longint unsigned cntMax[2] = '{64'hFFFF_FFFF, 64'd15};

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit same(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [1:0] fwdSrc(input logic [4:0] src, input stim_t s);
    if (s.rwM && same(src, s.wrM)) return 2'b10;
    if (s.rwW && same(src, s.wrW)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic outs_t predict(input int k, input stim_t s);
    outs_t e;
    bit lw, br, dv;
    e = '0;
    e.tmo = mTmo[k];
    e.cnt = 32'(mCnt[k]);
    if (s.rst) return e;
    e.fAE = fwdSrc(s.rsE, s);
    e.fBE = fwdSrc(s.rtE, s);
    e.fAD = s.rwM && same(s.rsD, s.wrM);
    e.fBD = s.rwM && same(s.rtD, s.wrM);
    lw = s.mtrE && (same(s.rtE, s.rsD) || same(s.rtE, s.rtD));
    br = s.branchD && ((s.rwE  && (same(s.wrE, s.rsD) || same(s.wrE, s.rtD))) ||
                       (s.mtrM && (same(s.wrM, s.rsD) || same(s.wrM, s.rtD))));
    dv = !mLeaving[k] && (mDividing[k] || s.divE);
    e.dStart = !mLeaving[k] && !mDividing[k] && s.divE;
    e.sF = lw || br || dv;
    e.sD = e.sF;
    e.sE = dv;
    e.fE = (lw || br) && !dv;
    e.fM = dv;
    return e;
  endfunction

  task automatic advance(input int k, input stim_t s, input bit stalled);
    if (s.rst) begin
      mDividing[k] = 0; mLeaving[k] = 0; mTmo[k] = 0; mBusy[k] = 0; mCnt[k] = 0;
      return;
    end
    if (stalled && mCnt[k] < cntMax[k]) mCnt[k]++;
    if (mLeaving[k]) begin
      mLeaving[k] = 0;
    end else if (mDividing[k]) begin
      mBusy[k]++;
      if (s.divReady || mBusy[k] == divMax[k]) begin
        if (!s.divReady) mTmo[k] = 1;
        mDividing[k] = 0;
        mLeaving[k]  = 1;
      end
    end else if (s.divE) begin
      mDividing[k] = 1;
      mBusy[k]     = 0;
    end
  endtask

  task automatic step(input stim_t s);
    outs_t e[2];
    outs_t o;
    string n;
    @(negedge clk);
    cur = s;
    #1;
    for (int k = 0; k < 2; k++) begin
      e[k] = predict(k, s);
      o = (k == 0) ? obsA : obsB;
      n = (k == 0) ? "A" : "B";
      checkEq({n, ".forwardAE"},   32'(o.fAE),    32'(e[k].fAE));
      checkEq({n, ".forwardBE"},   32'(o.fBE),    32'(e[k].fBE));
      checkEq({n, ".forwardAD"},   32'(o.fAD),    32'(e[k].fAD));
      checkEq({n, ".forwardBD"},   32'(o.fBD),    32'(e[k].fBD));
      checkEq({n, ".stallF"},      32'(o.sF),     32'(e[k].sF));
      checkEq({n, ".stallD"},      32'(o.sD),     32'(e[k].sD));
      checkEq({n, ".stallE"},      32'(o.sE),     32'(e[k].sE));
      checkEq({n, ".flushE"},      32'(o.fE),     32'(e[k].fE));
      checkEq({n, ".flushM"},      32'(o.fM),     32'(e[k].fM));
      checkEq({n, ".div_start"},   32'(o.dStart), 32'(e[k].dStart));
      checkEq({n, ".div_timeout"}, 32'(o.tmo),    32'(e[k].tmo));
      checkEq({n, ".stall_cycles"}, o.cnt,        e[k].cnt);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) advance(k, s, e[k].sF);
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '0;
    return s;
  endfunction

  initial begin
    stim_t s;
    cur = quiet();
    cur.rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) advance(k, cur, 1'b0);

    // reset state
    s = quiet(); s.rst = 1; s.divE = 1; s.mtrE = 1; s.rtE = 8; s.rsD = 8;
    step(s);

    // forwarding priority and $zero
    s = quiet(); s.rsE = 5; s.rwM = 1; s.wrM = 5; s.rwW = 1; s.wrW = 5; step(s);
    s.rwM = 0; step(s);
    s.rsE = 0; s.wrM = 0; s.rwM = 1; s.wrW = 0; step(s);

    // load-use
    s = quiet(); s.mtrE = 1; s.rtE = 8; s.rsD = 8; step(s);
    s = quiet(); step(s);

    // branch hazards
    s = quiet(); s.branchD = 1; s.rwE = 1; s.wrE = 3; s.rtD = 3; step(s);
    s = quiet(); s.branchD = 1; s.mtrM = 1; s.wrM = 4; s.rsD = 4; step(s);
    s = quiet(); s.branchD = 1; s.rwM = 1; s.wrM = 4; s.rsD = 4; step(s);

    // divide: launch + 5 busy with ready on the last, then DONE with divE still high
    for (int i = 0; i < 7; i++) begin
      s = quiet(); s.divE = 1; s.divReady = (i == 5); step(s);
    end
    s = quiet(); step(s);

    // long divide without ready: both instances time out
    for (int i = 0; i < 45; i++) begin
      s = quiet(); s.divE = 1; step(s);
    end
    s = quiet(); repeat (2) step(s);

    // reset mid-divide, then relaunch
    s = quiet(); s.divE = 1; repeat (3) step(s);
    s.rst = 1; step(s);
    s.rst = 0; repeat (3) step(s);
    s = quiet(); step(s);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst      = ($urandom_range(0, 299) == 0);
      s.rsD      = 5'($urandom_range(0, 7));
      s.rtD      = 5'($urandom_range(0, 7));
      s.rsE      = 5'($urandom_range(0, 7));
      s.rtE      = 5'($urandom_range(0, 7));
      s.wrE      = 5'($urandom_range(0, 7));
      s.wrM      = 5'($urandom_range(0, 7));
      s.wrW      = 5'($urandom_range(0, 7));
      s.rwE      = 1'($urandom_range(0, 1));
      s.rwM      = 1'($urandom_range(0, 1));
      s.rwW      = 1'($urandom_range(0, 1));
      s.mtrE     = ($urandom_range(0, 3) == 0);
      s.mtrM     = ($urandom_range(0, 3) == 0);
      s.branchD  = ($urandom_range(0, 2) == 0);
      s.divE     = ($urandom_range(0, 3) != 0);
      s.divReady = ($urandom_range(0, 7) == 0);
      step(s);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
